// File: rtl/tron_arena.sv
// tron_arena: multi-player light-cycle arena state keeper.
// Holds a {occupied, pid} map of a 2^X_BITS x 2^Y_BITS grid and accepts one
// move at a time over a valid/ready handshake. For each move it lays a wall
// behind the player, detects crashes against walls and other heads, tracks
// which players are alive and declares a winner or a draw. It also drives
// paint strobes for the VGA painter.
// Ports:
//   clock, reset (async, active-low), start (clear + new round)
//   move_valid/move_ready/move_player/move_x/move_y : move handshake
//   busy : clear sweep running; alive : per-player alive flags
//   crash_pulse/crash_player : crash strobe
//   game_over/winner_valid/winner/draw : round result
//   paint_head_* / paint_wall_* : painter strobes, position packed {y,x}
module tron_arena #(
  parameter int X_BITS      = 6,
  parameter int Y_BITS      = 6,
  parameter int NUM_PLAYERS = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic [1:0]                 move_player,
  input  logic [31:0]                move_x,
  input  logic [31:0]                move_y,
  output logic                       busy,
  output logic [NUM_PLAYERS-1:0]     alive,
  output logic                       crash_pulse,
  output logic [1:0]                 crash_player,
  output logic                       game_over,
  output logic                       winner_valid,
  output logic [1:0]                 winner,
  output logic                       draw,
  output logic                       paint_head_valid,
  output logic [X_BITS+Y_BITS-1:0]   paint_head_pos,
  output logic [3:0]                 paint_head_val,
  output logic                       paint_wall_valid,
  output logic [X_BITS+Y_BITS-1:0]   paint_wall_pos,
  output logic [3:0]                 paint_wall_val
);

  localparam int AW = X_BITS + Y_BITS;
  localparam logic [3:0] ALL_MASK = 4'((1 << NUM_PLAYERS) - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLAY, S_CHECK, S_OVER} state_t;

  state_t          r_state;
  logic [2:0]      r_map [1 << AW];
  logic [AW-1:0]   r_head [4];
  logic [3:0]      r_hv;
  logic [3:0]      r_alive;
  logic [AW-1:0]   r_clr_addr;
  logic [1:0]      r_mv_pid;
  logic [X_BITS-1:0] r_mv_x;
  logic [Y_BITS-1:0] r_mv_y;

  logic            r_move_ready, r_busy, r_crash_pulse, r_game_over;
  logic            r_winner_valid, r_draw, r_ph_valid, r_pw_valid;
  logic [1:0]      r_crash_player, r_winner;
  logic [AW-1:0]   r_ph_pos, r_pw_pos;
  logic [3:0]      r_ph_val, r_pw_val;

  logic [AW-1:0]   w_tgt, w_old;
  logic            w_first, w_active, w_occ, w_crash;
  logic [3:0]      w_hit, w_kill, w_alive_next;
  logic [2:0]      w_cnt;
  logic [1:0]      w_win;
  logic            w_unused;

  assign w_unused = &{1'b0, move_x[31:X_BITS], move_y[31:Y_BITS]};

  assign w_tgt    = {r_mv_y, r_mv_x};
  assign w_old    = r_head[r_mv_pid];
  assign w_first  = !r_hv[r_mv_pid];
  // Alive bits above NUM_PLAYERS are never set, so this also rejects bad ids.
  assign w_active = r_alive[r_mv_pid];
  assign w_occ    = r_map[w_tgt][2];

  always_comb begin
    w_hit = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (2'(j) != r_mv_pid && r_alive[j] && r_hv[j] && r_head[j] == w_tgt)
        w_hit[j] = 1'b1;
    end
  end

  // The old head becomes a wall in this same cycle, so a stationary move
  // must count as a crash even though the map read still shows it empty.
  assign w_crash = w_occ | (!w_first & ((w_tgt == w_old) | (|w_hit)));
  assign w_kill  = w_crash ? ((4'b0001 << r_mv_pid) | (w_first ? 4'b0000 : w_hit)) : 4'b0000;
  assign w_alive_next = r_alive & ~w_kill;

  always_comb begin
    w_cnt = '0;
    w_win = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      w_cnt = w_cnt + {2'b00, w_alive_next[j]};
      if (w_alive_next[j]) w_win = 2'(j);
    end
  end

  // Map storage has no reset; a clear sweep is required before play.
  always_ff @(posedge clock) begin
    if (r_state == S_CLEAR)
      r_map[r_clr_addr] <= '0;
    else if (r_state == S_CHECK && w_active && !w_first)
      r_map[w_old] <= {1'b1, r_mv_pid};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_hv           <= '0;
      r_alive        <= '0;
      r_clr_addr     <= '0;
      r_mv_pid       <= '0;
      r_mv_x         <= '0;
      r_mv_y         <= '0;
      r_move_ready   <= 1'b0;
      r_busy         <= 1'b0;
      r_crash_pulse  <= 1'b0;
      r_crash_player <= '0;
      r_game_over    <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner       <= '0;
      r_draw         <= 1'b0;
      r_ph_valid     <= 1'b0;
      r_ph_pos       <= '0;
      r_ph_val       <= '0;
      r_pw_valid     <= 1'b0;
      r_pw_pos       <= '0;
      r_pw_val       <= '0;
      for (int unsigned j = 0; j < 4; j++) r_head[j] <= '0;
    end else begin
      r_crash_pulse <= 1'b0;
      r_ph_valid    <= 1'b0;
      r_pw_valid    <= 1'b0;
      if (start) begin
        // Strobe for cell 0 is issued here so strobes line up with busy.
        r_state      <= S_CLEAR;
        r_clr_addr   <= '0;
        r_busy       <= 1'b1;
        r_move_ready <= 1'b0;
        r_pw_valid   <= 1'b1;
        r_pw_pos     <= '0;
        r_pw_val     <= '0;
      end else begin
        case (r_state)
          S_CLEAR: begin
            if (r_clr_addr == '1) begin
              r_state        <= S_PLAY;
              r_busy         <= 1'b0;
              r_move_ready   <= 1'b1;
              r_alive        <= ALL_MASK;
              r_hv           <= '0;
              r_game_over    <= 1'b0;
              r_winner_valid <= 1'b0;
              r_winner       <= '0;
              r_draw         <= 1'b0;
            end else begin
              r_clr_addr <= r_clr_addr + 1'b1;
              r_pw_valid <= 1'b1;
              r_pw_pos   <= r_clr_addr + 1'b1;
              r_pw_val   <= '0;
            end
          end
          S_PLAY: begin
            if (move_valid) begin
              r_mv_pid     <= move_player;
              r_mv_x       <= move_x[X_BITS-1:0];
              r_mv_y       <= move_y[Y_BITS-1:0];
              r_move_ready <= 1'b0;
              r_state      <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_active) begin
              if (!w_first) begin
                r_pw_valid <= 1'b1;
                r_pw_pos   <= w_old;
                r_pw_val   <= {2'b01, r_mv_pid};
              end
              if (w_crash) begin
                r_crash_pulse  <= 1'b1;
                r_crash_player <= r_mv_pid;
                r_alive        <= w_alive_next;
              end else begin
                r_head[r_mv_pid] <= w_tgt;
                r_hv[r_mv_pid]   <= 1'b1;
                r_ph_valid       <= 1'b1;
                r_ph_pos         <= w_tgt;
                r_ph_val         <= {2'b10, r_mv_pid};
              end
              if (w_cnt <= 3'd1) begin
                r_state        <= S_OVER;
                r_game_over    <= 1'b1;
                r_winner_valid <= (w_cnt == 3'd1);
                r_winner       <= w_win;
                r_draw         <= (w_cnt == 3'd0);
              end else begin
                r_state      <= S_PLAY;
                r_move_ready <= 1'b1;
              end
            end else begin
              r_state      <= S_PLAY;
              r_move_ready <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign move_ready       = r_move_ready;
  assign busy             = r_busy;
  assign alive            = r_alive[NUM_PLAYERS-1:0];
  assign crash_pulse      = r_crash_pulse;
  assign crash_player     = r_crash_player;
  assign game_over        = r_game_over;
  assign winner_valid     = r_winner_valid;
  assign winner           = r_winner;
  assign draw             = r_draw;
  assign paint_head_valid = r_ph_valid;
  assign paint_head_pos   = r_ph_pos;
  assign paint_head_val   = r_ph_val;
  assign paint_wall_valid = r_pw_valid;
  assign paint_wall_pos   = r_pw_pos;
  assign paint_wall_val   = r_pw_val;

endmodule

// File: tb/tb_tron_arena.sv
module tb_tron_arena;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        move_valid = 1'b0;
  logic        move_ready;
  logic [1:0]  move_player = '0;
  logic [31:0] move_x = '0;
  logic [31:0] move_y = '0;
  logic        busy;
  logic [1:0]  alive;
  logic        crash_pulse;
  logic [1:0]  crash_player;
  logic        game_over, winner_valid, draw;
  logic [1:0]  winner;
  logic        paint_head_valid, paint_wall_valid;
  logic [11:0] paint_head_pos, paint_wall_pos;
  logic [3:0]  paint_head_val, paint_wall_val;

  tron_arena #(.X_BITS(6), .Y_BITS(6), .NUM_PLAYERS(2)) dut (
    .clock(clock), .reset(reset), .start(start),
    .move_valid(move_valid), .move_ready(move_ready), .move_player(move_player),
    .move_x(move_x), .move_y(move_y), .busy(busy), .alive(alive),
    .crash_pulse(crash_pulse), .crash_player(crash_player),
    .game_over(game_over), .winner_valid(winner_valid), .winner(winner), .draw(draw),
    .paint_head_valid(paint_head_valid), .paint_head_pos(paint_head_pos),
    .paint_head_val(paint_head_val), .paint_wall_valid(paint_wall_valid),
    .paint_wall_pos(paint_wall_pos), .paint_wall_val(paint_wall_val)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected none", name, act);
  endtask

  typedef struct {
    logic [11:0] pos;
    logic [3:0]  val;
  } paint_t;

  paint_t     q_head[$];
  paint_t     q_wall[$];
  logic [1:0] q_crash[$];

  // Scoreboard side: every strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    paint_t e;
    if (reset) begin
      if (paint_head_valid) begin
        if (q_head.size() == 0) flag("head_unexpected", int'(paint_head_pos));
        else begin
          e = q_head.pop_front();
          chk("head_pos", int'(paint_head_pos), int'(e.pos));
          chk("head_val", int'(paint_head_val), int'(e.val));
        end
      end
      if (paint_wall_valid && !busy) begin
        if (q_wall.size() == 0) flag("wall_unexpected", int'(paint_wall_pos));
        else begin
          e = q_wall.pop_front();
          chk("wall_pos", int'(paint_wall_pos), int'(e.pos));
          chk("wall_val", int'(paint_wall_val), int'(e.val));
        end
      end
      if (crash_pulse) begin
        if (q_crash.size() == 0) flag("crash_unexpected", int'(crash_player));
        else chk("crash_player", int'(crash_player), int'(q_crash.pop_front()));
      end
    end
  end

  typedef struct {
    logic [1:0]  pid;
    int          x, y;
    bit          hv;
    logic [11:0] hpos;
    bit          wv;
    logic [11:0] wpos;
    bit          cr;
    logic [1:0]  exp_alive;
  } vec_t;

  vec_t tbl[10];

  // Called just after a negedge; returns after the sweep ends.
  task automatic run_clear(input int restart_at, output int n, output int bad);
    bad = 0;
    n = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (busy && n < 5000) begin
      if (!(paint_wall_valid && paint_wall_val == 4'd0 && int'(paint_wall_pos) == n)) bad++;
      if (n == restart_at) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        restart_at = -1;
      end else begin
        n++;
        @(negedge clock);
      end
    end
  endtask

  task automatic apply_vec(input int i);
    int k;
    if (tbl[i].hv) q_head.push_back('{tbl[i].hpos, {2'b10, tbl[i].pid}});
    if (tbl[i].wv) q_wall.push_back('{tbl[i].wpos, {2'b01, tbl[i].pid}});
    if (tbl[i].cr) q_crash.push_back(tbl[i].pid);
    move_valid  = 1'b1;
    move_player = tbl[i].pid;
    move_x      = 32'(tbl[i].x);
    move_y      = 32'(tbl[i].y);
    k = 0;
    while (!move_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (!move_ready) flag("ready_timeout", i);
    @(negedge clock);
    move_valid = 1'b0;
    @(negedge clock);
    #1;
    chk($sformatf("alive_%0d", i), int'(alive), int'(tbl[i].exp_alive));
    chk($sformatf("q_empty_%0d", i), q_head.size() + q_wall.size() + q_crash.size(), 0);
  endtask

  initial begin
    int n, bad;
    //        pid  x   y  hv  hpos  wv  wpos  cr  alive
    tbl[0] = '{2'd0,  5,  5, 1, 12'd325,  0, 12'd0,    0, 2'b11};
    tbl[1] = '{2'd0,  6,  5, 1, 12'd326,  1, 12'd325,  0, 2'b11};
    tbl[2] = '{2'd1, 10, 10, 1, 12'd650,  0, 12'd0,    0, 2'b11};
    tbl[3] = '{2'd1, 11, 10, 1, 12'd651,  1, 12'd650,  0, 2'b11};
    tbl[4] = '{2'd1, 10, 10, 0, 12'd0,    1, 12'd651,  1, 2'b01};
    tbl[5] = '{2'd0, 64,  0, 1, 12'd0,    0, 12'd0,    0, 2'b11};
    tbl[6] = '{2'd3,  1,  1, 0, 12'd0,    0, 12'd0,    0, 2'b11};
    tbl[7] = '{2'd0, 20, 20, 1, 12'd1300, 1, 12'd0,    0, 2'b11};
    tbl[8] = '{2'd1, 21, 20, 1, 12'd1301, 0, 12'd0,    0, 2'b11};
    tbl[9] = '{2'd1, 20, 20, 0, 12'd0,    1, 12'd1301, 1, 2'b00};

    #1;
    chk("rst_alive", int'(alive), 0);
    chk("rst_ready", int'(move_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_strobes", int'({paint_head_valid, paint_wall_valid, crash_pulse}), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_clear(-1, n, bad);
    chk("clear_len", n, 4096);
    chk("clear_strobes", bad, 0);
    chk("post_clear_alive", int'(alive), 3);
    chk("post_clear_ready", int'(move_ready), 1);

    for (int i = 0; i < 5; i++) apply_vec(i);
    chk("r1_over", int'(game_over), 1);
    chk("r1_winner_valid", int'(winner_valid), 1);
    chk("r1_winner", int'(winner), 0);
    chk("r1_draw", int'(draw), 0);
    chk("r1_ready", int'(move_ready), 0);

    run_clear(-1, n, bad);
    chk("clear2_len", n, 4096);
    chk("r2_over_cleared", int'(game_over), 0);
    for (int i = 5; i < 10; i++) apply_vec(i);
    chk("r2_over", int'(game_over), 1);
    chk("r2_draw", int'(draw), 1);
    chk("r2_winner_valid", int'(winner_valid), 0);

    run_clear(100, n, bad);
    chk("restart_len", n, 4096);
    chk("restart_strobes", bad, 0);

    // Accept a move, then pull reset while the block is in CHECK.
    move_valid  = 1'b1;
    move_player = 2'd0;
    move_x      = 32'd1;
    move_y      = 32'd1;
    @(negedge clock);
    move_valid = 1'b0;
    chk("pre_rst_alive", int'(alive), 3);
    reset = 1'b0;
    #1;
    chk("async_alive", int'(alive), 0);
    chk("async_ready", int'(move_ready), 0);
    chk("async_outs", int'({busy, game_over, winner_valid, draw, crash_pulse,
                             paint_head_valid, paint_wall_valid}), 0);
    @(negedge clock);
    @(negedge clock);
    chk("async_no_strobe", int'({paint_head_valid, paint_wall_valid, crash_pulse}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
